// File: rtl/uart_pkg.sv
// Shared UART definitions: tx FSM state encoding, line-level constants and the
// bit-counter width helper used by the transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // A single-bit counter is still needed when clog2 would give zero.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_tsr.sv
// Transmit shift register with its data-bit counter; shifts LSB-first and flags
// the last data bit of the frame.
module uart_tx_tsr
  import uart_pkg::*;
#(
  parameter int DATA_SIZE = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 shift,
  input  logic [DATA_SIZE-1:0] load_data,
  output logic                 serial_bit,
  output logic                 next_bit,
  output logic                 last_bit
);

  localparam int CW = cnt_width(DATA_SIZE);

  logic [DATA_SIZE-1:0] tsr;
  logic [CW-1:0]        bit_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      tsr     <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      tsr     <= load_data;
      bit_cnt <= '0;
    end else if (shift) begin
      tsr     <= tsr >> 1;
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // next_bit lets the top register the line value one bit ahead of the shift.
  assign serial_bit = tsr[0];
  assign next_bit   = tsr[1];
  assign last_bit   = (bit_cnt == CW'(DATA_SIZE - 1));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: holding register, frame FSM, stop counter and optional
// parity (enabled by defining TX_PARITY_EN). Bit timing comes from bit_tick.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_SIZE  = 7,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic                 data_write,
  output logic                 tx_ready,
  output logic                 tx_busy,
  input  logic                 bit_tick,
  output logic                 transmit_line
);

  localparam logic [2:0] S_IDLE   = TX_IDLE;
  localparam logic [2:0] S_START  = TX_START;
  localparam logic [2:0] S_DATA   = TX_DATA;
`ifdef TX_PARITY_EN
  localparam logic [2:0] S_PARITY = TX_PARITY;
`endif
  localparam logic [2:0] S_STOP   = TX_STOP;

  if (DATA_SIZE < 5 || DATA_SIZE > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_tx: unsupported parameter combination");
  end

  logic [2:0]           state;
  logic [2:0]           state_nx;
  logic [DATA_SIZE-1:0] thr;
  logic                 thr_full;
  logic                 load;
  logic                 shift;
  logic                 line_nx;
  logic                 serial_bit;
  logic                 next_bit;
  logic                 last_bit;
  logic                 stop_cnt;
  logic                 stop_last;
`ifdef TX_PARITY_EN
  logic                 parity_bit;
`endif

  assign tx_ready  = ~thr_full;
  assign stop_last = (STOP_BITS < 2) ? 1'b1 : stop_cnt;

  uart_tx_tsr #(
    .DATA_SIZE(DATA_SIZE)
  ) u_tsr (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .shift     (shift),
    .load_data (thr),
    .serial_bit(serial_bit),
    .next_bit  (next_bit),
    .last_bit  (last_bit)
  );

  // The line value is computed for the next state so the registered output
  // changes on the same edge as the state itself.
  always_comb begin
    state_nx = state;
    line_nx  = transmit_line;
    load     = 1'b0;
    shift    = 1'b0;
    if (bit_tick) begin
      case (state)
        S_IDLE: begin
          if (thr_full) begin
            state_nx = S_START;
            line_nx  = START_BIT;
            load     = 1'b1;
          end
        end
        S_START: begin
          state_nx = S_DATA;
          line_nx  = serial_bit;
        end
        S_DATA: begin
          shift = 1'b1;
          if (last_bit) begin
`ifdef TX_PARITY_EN
            state_nx = S_PARITY;
            line_nx  = parity_bit;
`else
            state_nx = S_STOP;
            line_nx  = STOP_BIT;
`endif
          end else begin
            line_nx = next_bit;
          end
        end
`ifdef TX_PARITY_EN
        S_PARITY: begin
          state_nx = S_STOP;
          line_nx  = STOP_BIT;
        end
`endif
        S_STOP: begin
          if (stop_last) begin
            if (thr_full) begin
              state_nx = S_START;
              line_nx  = START_BIT;
              load     = 1'b1;
            end else begin
              state_nx = S_IDLE;
              line_nx  = LINE_IDLE;
            end
          end
        end
        default: begin
          state_nx = S_IDLE;
          line_nx  = LINE_IDLE;
        end
      endcase
    end
  end

  // A transfer clears THR in the same cycle, so a coincident write is refused.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      transmit_line <= LINE_IDLE;
      tx_busy       <= 1'b0;
      thr           <= '0;
      thr_full      <= 1'b0;
      stop_cnt      <= 1'b0;
`ifdef TX_PARITY_EN
      parity_bit    <= 1'b0;
`endif
    end else begin
      state         <= state_nx;
      transmit_line <= line_nx;
      tx_busy       <= (state_nx != S_IDLE);
      if (load) begin
        thr      <= '0;
        thr_full <= 1'b0;
      end else if (data_write && !thr_full) begin
        thr      <= data_in;
        thr_full <= 1'b1;
      end
      if (state != S_STOP)
        stop_cnt <= 1'b0;
      else if (bit_tick)
        stop_cnt <= ~stop_cnt;
`ifdef TX_PARITY_EN
      if (load)
        parity_bit <= (^thr) ^ (PARITY_ODD != 0);
`endif
    end
  end

endmodule
